bin2bcd_seg: RTL and testbench
==============================

BIN2BCD_SEG -- requirements
Module: bin2bcd_seg

Interface
REQ-001 Parameter WIDTH, default 6, binary input width in bits (legal range 1..20).
REQ-002 Parameter DIGITS, default 2, number of decimal digits and seven-segment outputs (legal range 1..6).
REQ-003 Parameter BLANK_LZ, default 1, 1 = leading zeros blanked, 0 = all digits shown.
REQ-004 Parameter ACTIVE_LOW, default 0, 1 = every segment output bit inverted at the port.
REQ-005 CLK  input  1  single clock; all state changes on the rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 START  input  1  conversion request, sampled on the rising edge of CLK.
REQ-008 SW  input  WIDTH  unsigned binary value, captured on an accepted START.
REQ-009 BUSY  output  1  high while a conversion is in progress.
REQ-010 DONE  output  1  one-cycle pulse when new HEX and OVF values become valid.
REQ-011 OVF  output  1  last conversion result was >= 10^DIGITS.
REQ-012 HEX  output  7*DIGITS  registered segment patterns; HEX[7k+6:7k] drives digit k (k=0 is the units digit); bit order gfedcba, bit 0 = a.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and LOAD.
REQ-014 IDLE with START=1: capture SW into the shift register, clear the BCD accumulator and the bit counter, go to SHIFT; BUSY=1 from the next cycle.
REQ-015 IDLE with START=0: remain in IDLE; hold all outputs.
REQ-016 SHIFT, each cycle: add 3 to every BCD nibble that is >= 5, then shift {BCD, binary} left by 1; repeat for exactly WIDTH cycles, then go to LOAD.
REQ-017 Accumulator width: 4*DIGITS+4 bits; the extra guard nibble captures any value >= 10^DIGITS.
REQ-018 LOAD, one cycle: register HEX and OVF from the accumulator, pulse DONE=1, drop BUSY to 0, return to IDLE.
REQ-019 Latency: START accepted at edge 0 -> DONE=1 and new HEX visible after edge WIDTH+1; no new START is accepted before edge WIDTH+2.
REQ-020 START while BUSY=1 or in LOAD: ignored, with no queuing and no effect on the conversion in progress.
REQ-021 SW changes after capture: no effect on the conversion in progress.
REQ-022 Segment encoding (ACTIVE_LOW=0) for digits 0-9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
REQ-023 Blank = 0000000; dash = 1000000 (g only).
REQ-024 BLANK_LZ=1: every zero digit above the most significant nonzero digit is blank; digit 0 is never blanked, so a value of 0 shows "0".
REQ-025 OVF=1 (guard nibble nonzero): all DIGITS outputs show dash, regardless of BLANK_LZ.
REQ-026 ACTIVE_LOW=1: bitwise inversion applies to all HEX patterns, including blank and dash.
REQ-027 Between DONE pulses, HEX and OVF SHALL hold the last loaded values.

Reset
REQ-028 RST=1 asynchronously forces: state IDLE, BUSY=0, DONE=0, OVF=0, HEX = all digits blank (polarity per ACTIVE_LOW), accumulator and counter cleared.
REQ-029 RST asserted during SHIFT or LOAD: the conversion is aborted and no DONE is issued.
REQ-030 After RST deasserts, the first START is accepted on the next rising edge of CLK.

Verification
REQ-031 Default parameters, SW=45, START pulse at edge 0 -> BUSY=1 during edges 1-6, DONE=1 after edge 7, HEX[13:7]=1100110 (4), HEX[6:0]=1101101 (5), OVF=0.
REQ-032 SW=0 and SW=7 with BLANK_LZ=1 -> HEX[6:0]=0111111 / 0000111, HEX[13:7]=0000000; repeat with BLANK_LZ=0 -> HEX[13:7]=0111111.
REQ-033 DIGITS=1, SW=63 -> OVF=1, HEX[6:0]=1000000; next SW=9 -> OVF=0, HEX[6:0]=1101111.
REQ-034 WIDTH=10, DIGITS=3, SW=999 -> 9/9/9 on all three digits after 11 cycles; SW=1000 -> OVF=1 and three dashes.
REQ-035 START held high continuously with SW=45 -> exactly one DONE every WIDTH+2 cycles; SW changed mid-conversion does not alter the result.
REQ-036 RST pulsed at SHIFT cycle 3 -> BUSY=0 immediately, no DONE, HEX blank; a new START with SW=12 -> "12" displayed with normal latency.

Source files
------------

// File: rtl/bin2bcd_seg.sv
// Sequential binary-to-BCD converter (shift-and-add-3) driving
// registered seven-segment patterns with optional leading-zero blanking.
module bin2bcd_seg #(
    parameter int WIDTH      = 6,
    parameter int DIGITS     = 2,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [WIDTH-1:0]      SW,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int BW = 4 * DIGITS + 4;
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic [7*DIGITS-1:0] BLANK = INV ? '1 : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t               state;
    logic [WIDTH-1:0]     bin;
    logic [BW-1:0]        bcd;
    logic [BW-1:0]        adj;
    logic [CW-1:0]        cnt;
    logic                 lost;
    logic [7*DIGITS-1:0]  seg_next;
    logic                 ovf_next;
    logic                 seen;
    logic [3:0]           dig;
    logic [6:0]           pat;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // The guard nibble is adjusted too so it stays a proper BCD digit.
    always_comb begin
        adj = bcd;
        for (int i = 0; i <= DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Bits shifted out of the guard nibble are remembered in 'lost'.
    always_comb begin
        ovf_next = lost | (|bcd[BW-1 -: 4]);
        seg_next = '0;
        seen     = 1'b0;
        dig      = '0;
        pat      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dig = bcd[4*k +: 4];
            if (dig != 4'd0)
                seen = 1'b1;
            if (ovf_next)
                pat = 7'b1000000;
            else if (BLANK_LZ != 0 && k != 0 && !seen)
                pat = 7'b0000000;
            else
                pat = seg7(dig);
            seg_next[7*k +: 7] = pat ^ {7{INV}};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            OVF   <= 1'b0;
            HEX   <= BLANK;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            lost  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        bin   <= SW;
                        bcd   <= '0;
                        cnt   <= '0;
                        lost  <= 1'b0;
                        BUSY  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {adj[BW-2:0], bin[WIDTH-1]};
                    bin  <= bin << 1;
                    lost <= lost | adj[BW-1];
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= LOAD;
                end
                LOAD: begin
                    HEX   <= seg_next;
                    OVF   <= ovf_next;
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seg.sv
// Scoreboard bench for bin2bcd_seg across several parameter sets
// driven from one linear directed sequence.
module tb_bin2bcd_seg;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        START3 = 1'b0;
    logic [5:0]  SW = '0;
    logic [9:0]  SW3 = '0;

    logic busy0, done0, ovf0;
    logic busy1, done1, ovf1;
    logic busy2, done2, ovf2;
    logic busy3, done3, ovf3;
    logic busy4, done4, ovf4;
    logic [13:0] hex0, hex1, hex4;
    logic [6:0]  hex2;
    logic [20:0] hex3;

    bin2bcd_seg d0 (.CLK(CLK), .RST(RST), .START(START), .SW(SW),
                    .BUSY(busy0), .DONE(done0), .OVF(ovf0), .HEX(hex0));
    bin2bcd_seg #(.BLANK_LZ(0)) d1 (.CLK(CLK), .RST(RST), .START(START),
                    .SW(SW), .BUSY(busy1), .DONE(done1), .OVF(ovf1), .HEX(hex1));
    bin2bcd_seg #(.DIGITS(1)) d2 (.CLK(CLK), .RST(RST), .START(START),
                    .SW(SW), .BUSY(busy2), .DONE(done2), .OVF(ovf2), .HEX(hex2));
    bin2bcd_seg #(.WIDTH(10), .DIGITS(3)) d3 (.CLK(CLK), .RST(RST),
                    .START(START3), .SW(SW3), .BUSY(busy3), .DONE(done3),
                    .OVF(ovf3), .HEX(hex3));
    bin2bcd_seg #(.ACTIVE_LOW(1)) d4 (.CLK(CLK), .RST(RST), .START(START),
                    .SW(SW), .BUSY(busy4), .DONE(done4), .OVF(ovf4), .HEX(hex4));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [13:0] h0;
        logic [13:0] h1;
        logic [13:0] h4;
        logic [6:0]  h2;
        logic        o0;
        logic        o2;
    } exp6_t;

    exp6_t       q6[$];
    logic [21:0] q10[$];
    exp6_t       me;
    logic [21:0] me3;
    int errors = 0;
    int checks = 0;
    int ndone = 0;
    int cyc = 0;
    int last_done = 0;
    int last_gap = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h3f;
            1: return 7'h06;
            2: return 7'h5b;
            3: return 7'h4f;
            4: return 7'h66;
            5: return 7'h6d;
            6: return 7'h7d;
            7: return 7'h07;
            8: return 7'h7f;
            default: return 7'h6f;
        endcase
    endfunction

    // Decimal reference: {ovf, hex}
    function automatic logic [21:0] model(input int v, input int digits,
                                          input bit blz, input bit al);
        logic [20:0] h;
        logic [6:0]  p7;
        int p;
        int lim;
        bit ov;
        h = '0;
        lim = 1;
        for (int k = 0; k < digits; k++) lim = lim * 10;
        ov = (v >= lim);
        p = 1;
        for (int k = 0; k < digits; k++) begin
            if (ov) p7 = 7'h40;
            else if (blz && k > 0 && v < p) p7 = 7'h00;
            else p7 = seg((v / p) % 10);
            if (al) p7 = ~p7;
            h[7*k +: 7] = p7;
            p = p * 10;
        end
        return {ov, h};
    endfunction

    function automatic exp6_t mk6(input int v);
        exp6_t e;
        logic [21:0] m;
        m = model(v, 2, 1, 0); e.h0 = m[13:0]; e.o0 = m[21];
        m = model(v, 2, 0, 0); e.h1 = m[13:0];
        m = model(v, 1, 1, 0); e.h2 = m[6:0];  e.o2 = m[21];
        m = model(v, 2, 1, 1); e.h4 = m[13:0];
        return e;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (done0) begin
            ndone++;
            last_gap = cyc - last_done;
            last_done = cyc;
            if (q6.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                me = q6.pop_front();
                chk("hex0", hex0, me.h0);
                chk("ovf0", ovf0, me.o0);
                chk("hex1_nblank", hex1, me.h1);
                chk("hex2_d1", hex2, me.h2);
                chk("ovf2_d1", ovf2, me.o2);
                chk("hex4_al", hex4, me.h4);
                chk("done_sync", {done1, done2, done4}, 3'b111);
            end
        end
        if (done3) begin
            if (q10.size() == 0) begin
                chk("unexpected_done3", 1, 0);
            end else begin
                me3 = q10.pop_front();
                chk("hex3", hex3, me3[20:0]);
                chk("ovf3", ovf3, me3[21]);
            end
        end
    end

    task automatic run6(input int v, input bit poke);
        exp6_t e;
        int n;
        bit busy_ok;
        e = mk6(v);
        @(negedge CLK);
        SW = 6'(v);
        START = 1'b1;
        q6.push_back(e);
        @(posedge CLK); #1;
        START = 1'b0;
        SW = ~6'(v);
        busy_ok = 1'b1;
        n = 0;
        while (n < 30) begin
            @(posedge CLK); #1;
            n++;
            if (poke && n == 3) begin
                START = 1'b1;
                SW = 6'd38;
            end
            if (poke && n == 4) START = 1'b0;
            if (done0) break;
            if (!busy0) busy_ok = 1'b0;
        end
        chk("latency6", n, 7);
        chk("busy6", busy_ok, 1);
        chk("busy_drop", busy0, 0);
        @(posedge CLK); #1;
        chk("done_pulse", done0, 0);
        chk("hold", hex0, e.h0);
    endtask

    task automatic run10(input int v);
        logic [21:0] m;
        int n;
        m = model(v, 3, 1, 0);
        @(negedge CLK);
        SW3 = 10'(v);
        START3 = 1'b1;
        q10.push_back(m);
        @(posedge CLK); #1;
        START3 = 1'b0;
        SW3 = '0;
        n = 0;
        while (n < 40) begin
            @(posedge CLK); #1;
            n++;
            if (done3) break;
        end
        chk("latency10", n, 11);
        @(posedge CLK); #1;
        chk("done3_pulse", done3, 0);
        chk("hold3", hex3, m[20:0]);
    endtask

    initial begin
        exp6_t e45;
        int nd;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_hex0", hex0, 14'h0000);
        chk("rst_hex4", hex4, 14'h3fff);
        chk("rst_hex3", hex3, 21'h0);
        chk("rst_hex2", hex2, 7'h00);
        @(negedge CLK);
        RST = 1'b0;

        run6(45, 0);
        run6(0, 0);
        run6(7, 1);
        run6(63, 0);
        run6(9, 0);
        run10(999);
        run10(1000);
        run10(0);

        e45 = mk6(45);
        nd = ndone;
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            START = 1'b1;
            SW = (i % 8 == 0) ? 6'd45 : 6'(i * 5 + 1);
            if (i % 8 == 0) q6.push_back(e45);
        end
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("cont_count", ndone - nd, 3);
        chk("cont_gap", last_gap, 8);

        @(negedge CLK);
        SW = 6'd33;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        SW = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_hex", hex0, 14'h0000);
        chk("abort_hex4", hex4, 14'h3fff);
        chk("abort_done", done0, 0);
        nd = ndone;
        @(negedge CLK);
        RST = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        chk("abort_no_done", ndone - nd, 0);
        run6(12, 0);
        chk("queue_empty", q6.size() + q10.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
